// File: rtl/vp_pkg.sv
// vp_pkg: shared register-reference types and sizing for the vector pipeline.
package vp_pkg;
  localparam int REG_IDX_W = 4;
  localparam int NREG = 16;
  typedef enum logic {BANK_SCALAR = 1'b0, BANK_VECTOR = 1'b1} bank_t;
  typedef struct {logic en; bank_t bank; logic [REG_IDX_W-1:0] idx;} reg_ref_t;
  function automatic logic [REG_IDX_W:0] flat_idx(reg_ref_t r);
    return {r.bank, r.idx};
  endfunction
endpackage

// File: rtl/sb_counter.sv
// sb_counter: saturating up/down outstanding-write counter with clear.
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         nz
);
  assign nz = |cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !(dec && nz) && !(&cnt)) cnt <= cnt + W'(1);
    else if (dec && nz && !inc) cnt <= cnt - W'(1);
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW/WAW interlock tracking in-flight scalar and vector destinations.
module hazard_scoreboard
  import vp_pkg::*;
#(
  parameter int CNT_W  = 2,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [3:0]        id_src1,
  input  logic              id_src1_vec,
  input  logic              id_src1_en,
  input  logic [3:0]        id_src2,
  input  logic              id_src2_vec,
  input  logic              id_src2_en,
  input  logic [3:0]        id_dst,
  input  logic              id_dst_vec,
  input  logic              id_dst_en,
  output logic              id_stall,
  output logic              issue,
  input  logic              wb_valid,
  input  logic [3:0]        wb_dst,
  input  logic              wb_dst_vec,
  input  logic              flush,
  output logic [NREG-1:0]   pend_s,
  output logic [NREG-1:0]   pend_v,
  output logic [PERF_W-1:0] stall_cnt,
  output logic              err
);
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [CNT_W-1:0] cnt [2*NREG];
  logic [2*NREG-1:0] nz;
  reg_ref_t s1, s2, d;
  logic [REG_IDX_W:0] wb_idx, d_idx;
  logic s1_haz, s2_haz, d_haz;
  assign s1 = '{en: id_src1_en, bank: bank_t'(id_src1_vec), idx: id_src1};
  assign s2 = '{en: id_src2_en, bank: bank_t'(id_src2_vec), idx: id_src2};
  assign d  = '{en: id_dst_en,  bank: bank_t'(id_dst_vec),  idx: id_dst};
  assign d_idx  = flat_idx(d);
  assign wb_idx = {wb_dst_vec, wb_dst};
  // Hazards look only at registered counts, so a same-cycle writeback never bypasses.
  assign s1_haz = s1.en & nz[flat_idx(s1)];
  assign s2_haz = s2.en & nz[flat_idx(s2)];
  assign d_haz  = d.en & (cnt[d_idx] == CMAX);
  assign id_stall = id_valid & (s1_haz | s2_haz | d_haz | flush);
  assign issue    = id_valid & ~id_stall;
  for (genvar i = 0; i < 2*NREG; i++) begin : g_cnt
    sb_counter #(.W(CNT_W)) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (issue & id_dst_en & (d_idx == (REG_IDX_W+1)'(i))),
      .dec  (wb_valid & (wb_idx == (REG_IDX_W+1)'(i))),
      .clr  (flush),
      .cnt  (cnt[i]),
      .nz   (nz[i])
    );
  end
  assign pend_s = nz[NREG-1:0];
  assign pend_v = nz[2*NREG-1:NREG];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (id_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + PERF_W'(1);
      if (wb_valid && !flush && !nz[wb_idx]) err <= 1'b1;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and randomized checks against a counting reference model.
module tb_hazard_scoreboard;
  logic clk = 1'b0, rst_n;
  logic id_valid, id_src1_vec, id_src1_en, id_src2_vec, id_src2_en, id_dst_vec, id_dst_en;
  logic [3:0] id_src1, id_src2, id_dst, wb_dst;
  logic wb_valid, wb_dst_vec, flush;
  logic id_stall, issue, err;
  logic [15:0] pend_s, pend_v, stall_cnt;
  int vec_n = 0, miss = 0;
  int mc [2][16];
  bit m_err;
  int m_sc;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_src1(id_src1), .id_src1_vec(id_src1_vec), .id_src1_en(id_src1_en),
    .id_src2(id_src2), .id_src2_vec(id_src2_vec), .id_src2_en(id_src2_en),
    .id_dst(id_dst), .id_dst_vec(id_dst_vec), .id_dst_en(id_dst_en),
    .id_stall(id_stall), .issue(issue), .wb_valid(wb_valid), .wb_dst(wb_dst),
    .wb_dst_vec(wb_dst_vec), .flush(flush), .pend_s(pend_s), .pend_v(pend_v),
    .stall_cnt(stall_cnt), .err(err)
  );

  always #5 clk = ~clk;

  function automatic bit m_stall();
    if (!id_valid) return 1'b0;
    return (id_src1_en && mc[id_src1_vec][id_src1] != 0) ||
           (id_src2_en && mc[id_src2_vec][id_src2] != 0) ||
           (id_dst_en && mc[id_dst_vec][id_dst] == 3) || flush;
  endfunction

  function automatic logic [15:0] m_pend(int b);
    logic [15:0] p;
    for (int i = 0; i < 16; i++) p[i] = mc[b][i] != 0;
    return p;
  endfunction

  task automatic m_clear();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 16; i++) mc[b][i] = 0;
  endtask

  task automatic idle();
    id_valid = 0; id_src1 = 0; id_src1_vec = 0; id_src1_en = 0;
    id_src2 = 0; id_src2_vec = 0; id_src2_en = 0;
    id_dst = 0; id_dst_vec = 0; id_dst_en = 0;
    wb_valid = 0; wb_dst = 0; wb_dst_vec = 0; flush = 0;
  endtask

  task automatic tick();
    bit st, is;
    st = m_stall();
    is = id_valid && !st;
    @(posedge clk);
    if (flush) m_clear();
    else begin
      if (wb_valid) begin
        if (mc[wb_dst_vec][wb_dst] == 0) m_err = 1;
        else mc[wb_dst_vec][wb_dst]--;
      end
      if (is && id_dst_en) mc[id_dst_vec][id_dst]++;
    end
    if (st && m_sc < 65535) m_sc++;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0; m_clear(); m_err = 0; m_sc = 0;
    id_valid = 1;
    #2;
    vec_n++; if (id_stall !== 1'b0 || issue !== 1'b1) begin miss++; $display("FAIL reset_comb: stall=%b issue=%b want 0/1", id_stall, issue); end
    vec_n++; if (pend_s !== 16'h0 || pend_v !== 16'h0) begin miss++; $display("FAIL reset_pend: s=%h v=%h want 0", pend_s, pend_v); end
    vec_n++; if (stall_cnt !== 16'h0 || err !== 1'b0) begin miss++; $display("FAIL reset_cnt: cnt=%h err=%b want 0/0", stall_cnt, err); end
    rst_n = 1;
    idle();
    tick();
  endtask

  task automatic test_raw();
    int sc0;
    sc0 = m_sc;
    idle(); id_valid = 1; id_dst = 5; id_dst_en = 1;
    #1;
    vec_n++; if (issue !== 1'b1) begin miss++; $display("FAIL raw_issue: got %b want 1", issue); end
    tick();
    vec_n++; if (pend_s[5] !== 1'b1) begin miss++; $display("FAIL raw_pend: got %b want 1", pend_s[5]); end
    idle(); id_valid = 1; id_src1 = 5; id_src1_en = 1;
    #1;
    vec_n++; if (id_stall !== 1'b1) begin miss++; $display("FAIL raw_stall: got %b want 1", id_stall); end
    tick(); tick();
    wb_valid = 1; wb_dst = 5;
    #1;
    vec_n++; if (id_stall !== 1'b1) begin miss++; $display("FAIL raw_nobypass: got %b want 1", id_stall); end
    tick();
    wb_valid = 0;
    #1;
    vec_n++; if (id_stall !== 1'b0 || issue !== 1'b1) begin miss++; $display("FAIL raw_release: stall=%b issue=%b want 0/1", id_stall, issue); end
    vec_n++; if (pend_s[5] !== 1'b0) begin miss++; $display("FAIL raw_pend_clear: got %b want 0", pend_s[5]); end
    vec_n++; if (32'(stall_cnt) !== sc0 + 3) begin miss++; $display("FAIL raw_stall_cnt: got %0d want %0d", stall_cnt, sc0 + 3); end
    tick();
  endtask

  task automatic test_bank();
    idle(); id_valid = 1; id_dst = 3; id_dst_vec = 1; id_dst_en = 1;
    tick();
    idle(); id_valid = 1; id_src1 = 3; id_src1_en = 1; id_src2 = 3; id_src2_en = 1;
    #1;
    vec_n++; if (id_stall !== 1'b0 || issue !== 1'b1) begin miss++; $display("FAIL bank_iso: stall=%b issue=%b want 0/1", id_stall, issue); end
    id_src2_vec = 1;
    #1;
    vec_n++; if (id_stall !== 1'b1) begin miss++; $display("FAIL bank_vec_src2: got %b want 1", id_stall); end
    idle(); wb_valid = 1; wb_dst = 3; wb_dst_vec = 1;
    tick();
    idle();
    #1;
    vec_n++; if (pend_v !== m_pend(1)) begin miss++; $display("FAIL bank_pend_v: got %h want %h", pend_v, m_pend(1)); end
  endtask

  task automatic test_waw();
    idle(); id_valid = 1; id_dst = 7; id_dst_vec = 1; id_dst_en = 1;
    tick(); tick(); tick();
    vec_n++; if (pend_v[7] !== 1'b1) begin miss++; $display("FAIL waw_pend: got %b want 1", pend_v[7]); end
    vec_n++; if (id_stall !== 1'b1) begin miss++; $display("FAIL waw_sat_stall: got %b want 1", id_stall); end
    wb_valid = 1; wb_dst = 7; wb_dst_vec = 1;
    #1;
    vec_n++; if (id_stall !== 1'b1) begin miss++; $display("FAIL waw_wb_cycle: got %b want 1", id_stall); end
    tick();
    wb_valid = 0;
    #1;
    vec_n++; if (issue !== 1'b1) begin miss++; $display("FAIL waw_fourth_issue: got %b want 1", issue); end
    tick();
    #1;
    vec_n++; if (id_stall !== 1'b1) begin miss++; $display("FAIL waw_back_to_3: got %b want 1", id_stall); end
    idle(); wb_valid = 1; wb_dst = 7; wb_dst_vec = 1;
    tick(); tick(); tick();
    idle();
    #1;
    vec_n++; if (pend_v[7] !== 1'b0) begin miss++; $display("FAIL waw_drain: got %b want 0", pend_v[7]); end
  endtask

  task automatic test_simul();
    idle(); id_valid = 1; id_dst = 2; id_dst_en = 1;
    tick();
    wb_valid = 1; wb_dst = 2;
    tick();
    vec_n++; if (pend_s[2] !== 1'b1) begin miss++; $display("FAIL simul_keep: got %b want 1", pend_s[2]); end
    idle(); wb_valid = 1; wb_dst = 2;
    tick();
    idle();
    vec_n++; if (pend_s[2] !== 1'b0) begin miss++; $display("FAIL simul_clear: got %b want 0", pend_s[2]); end
  endtask

  task automatic test_flush();
    idle(); id_valid = 1; id_dst = 1; id_dst_en = 1;
    tick();
    id_dst = 9; id_dst_vec = 1;
    tick();
    idle(); id_valid = 1; flush = 1;
    #1;
    vec_n++; if (id_stall !== 1'b1) begin miss++; $display("FAIL flush_stall: got %b want 1", id_stall); end
    vec_n++; if (pend_s[1] !== 1'b1 || pend_v[9] !== 1'b1) begin miss++; $display("FAIL flush_pre: s1=%b v9=%b want 1/1", pend_s[1], pend_v[9]); end
    tick();
    idle();
    vec_n++; if (pend_s !== 16'h0 || pend_v !== 16'h0) begin miss++; $display("FAIL flush_clear: s=%h v=%h want 0", pend_s, pend_v); end
    vec_n++; if (err !== 1'b0) begin miss++; $display("FAIL flush_err_pre: got %b want 0", err); end
    wb_valid = 1; wb_dst = 1;
    tick();
    idle();
    vec_n++; if (err !== 1'b1 || pend_s !== 16'h0) begin miss++; $display("FAIL spurious_wb: err=%b s=%h want 1/0", err, pend_s); end
  endtask

  task automatic test_random();
    bit exp_st;
    for (int n = 0; n < 2000; n++) begin
      id_valid = $urandom_range(0, 3) != 0;
      id_src1 = 4'($urandom_range(0, 3)); id_src1_vec = 1'($urandom); id_src1_en = 1'($urandom);
      id_src2 = 4'($urandom_range(0, 3)); id_src2_vec = 1'($urandom); id_src2_en = 1'($urandom);
      id_dst = 4'($urandom_range(0, 3)); id_dst_vec = 1'($urandom); id_dst_en = $urandom_range(0, 3) != 0;
      wb_valid = 1'($urandom); wb_dst = 4'($urandom_range(0, 3)); wb_dst_vec = 1'($urandom);
      flush = $urandom_range(0, 24) == 0;
      #1;
      exp_st = m_stall();
      vec_n++; if (id_stall !== exp_st || issue !== (id_valid && !exp_st)) begin miss++; $display("FAIL rnd_comb[%0d]: stall=%b issue=%b want %b/%b", n, id_stall, issue, exp_st, id_valid && !exp_st); end
      tick();
      vec_n++; if (pend_s !== m_pend(0) || pend_v !== m_pend(1)) begin miss++; $display("FAIL rnd_pend[%0d]: s=%h v=%h want %h/%h", n, pend_s, pend_v, m_pend(0), m_pend(1)); end
      vec_n++; if (32'(stall_cnt) !== m_sc || err !== m_err) begin miss++; $display("FAIL rnd_regs[%0d]: cnt=%0d err=%b want %0d/%b", n, stall_cnt, err, m_sc, m_err); end
    end
    idle(); flush = 1;
    tick();
    idle();
  endtask

  task automatic test_sat_reset();
    int guard;
    idle(); id_valid = 1; id_dst = 4; id_dst_en = 1;
    tick();
    idle(); id_valid = 1; id_src1 = 4; id_src1_en = 1;
    guard = 0;
    while (m_sc < 65535 && guard < 70000) begin tick(); guard++; end
    repeat (4) tick();
    vec_n++; if (stall_cnt !== 16'hFFFF) begin miss++; $display("FAIL sat_hold: got %h want ffff", stall_cnt); end
    vec_n++; if (id_stall !== 1'b1 || pend_s[4] !== 1'b1) begin miss++; $display("FAIL sat_stalling: stall=%b pend=%b want 1/1", id_stall, pend_s[4]); end
    #2;
    rst_n = 0;
    m_clear(); m_err = 0; m_sc = 0;
    #1;
    vec_n++; if (stall_cnt !== 16'h0 || err !== 1'b0) begin miss++; $display("FAIL async_rst_regs: cnt=%h err=%b want 0/0", stall_cnt, err); end
    vec_n++; if (pend_s !== 16'h0 || pend_v !== 16'h0) begin miss++; $display("FAIL async_rst_pend: s=%h v=%h want 0", pend_s, pend_v); end
    vec_n++; if (id_stall !== 1'b0 || issue !== 1'b1) begin miss++; $display("FAIL async_rst_stall: stall=%b issue=%b want 0/1", id_stall, issue); end
    #1;
    rst_n = 1;
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_bank();
    test_waw();
    test_simul();
    test_flush();
    test_random();
    test_sat_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss);
    $finish;
  end
endmodule
